matrix_slot_manager: RTL and testbench
======================================

Name: matrix_slot_manager

Overview:
- Matrix storage bookkeeper that serves the alloc/commit handshake of the generate and input modes.
- Owns 16 fixed-stride BRAM regions ("slots"), tracks each slot as FREE, RESERVED or VALID, and enforces the per-size matrix limit by evicting the oldest matrix of the same dimensions.
- Provides a registered lookup port for display/compute modes.

Parameters:
- ADDR_WIDTH, 12, BRAM element address width.
- SLOT_STRIDE, 256, elements per slot region (16x16 max); slot base = slot*SLOT_STRIDE.
- NUM_SLOTS, 16, number of slots (slot index 4 bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- config_matrices_per_size  in  8  max matrices stored per (m,n); 0 treated as 1
- alloc_req  in  1  level request, held until alloc_valid seen
- alloc_m  in  5  requested rows
- alloc_n  in  5  requested cols
- alloc_valid  out  1  one-cycle grant pulse
- alloc_slot  out  4  granted slot
- alloc_addr  out  ADDR_WIDTH  granted base address
- alloc_error  out  1  one-cycle refusal pulse
- commit_req  in  1  commit strobe, rising-edge detected
- commit_slot  in  4  slot to commit
- commit_m  in  5  committed rows
- commit_n  in  5  committed cols
- commit_addr  in  ADDR_WIDTH  committed base (checked)
- alloc_cancel  in  1  pulse: release every RESERVED slot to FREE
- clear_all  in  1  pulse: all slots FREE, sequence counter 0
- query_slot  in  4  lookup index
- query_valid  out  1  slot VALID (1-cycle latency)
- query_m  out  5  rows of queried slot
- query_n  out  5  cols of queried slot
- query_addr  out  ADDR_WIDTH  base of queried slot
- valid_count  out  5  number of VALID slots
- commit_error  out  1  one-cycle pulse on bad commit

Behaviour:
- Reset: all slots FREE, dims 0, stamps 0; seq counter 0; FSM IDLE. Outputs alloc_valid, alloc_error, commit_error, query_valid = 0; alloc_slot, alloc_addr, query_m, query_n, query_addr = 0; valid_count = 0. Reset mid-scan discards the request.
- Per-slot state: 2-bit status, 5-bit m, 5-bit n, 8-bit commit stamp. Global 8-bit seq increments per accepted commit and wraps. Age = seq - stamp (mod 256); largest age = oldest.
- FSM IDLE:
  - alloc_req=1 with m or n in {0, >16}: alloc_error pulse next cycle, then WAIT_DROP.
  - Otherwise latch m/n and go to SCAN.
- FSM SCAN: 16 cycles, one slot per cycle, index 0..15. Accumulates:
  - first FREE slot (lowest index);
  - same-size count (RESERVED or VALID with equal m and n);
  - oldest VALID same-size slot;
  - oldest VALID slot overall (lowest index wins ties).
- FSM DECIDE, priority order:
  - (a) same-size count >= limit: evict oldest VALID same-size slot;
  - (b) else first FREE slot;
  - (c) else oldest VALID slot overall;
  - (d) none available (all RESERVED, or (a) with no VALID same-size slot): alloc_error.
  - Chosen slot becomes RESERVED with latched dims.
- FSM GRANT: alloc_valid=1 for one cycle with alloc_slot and alloc_addr = slot*SLOT_STRIDE. Latency: alloc_valid exactly 18 cycles after the first IDLE cycle sampling alloc_req=1.
- FSM WAIT_DROP: wait until alloc_req=0, then IDLE. A level held across the grant must never cause a second grant.
- Commit, any FSM state, on commit_req rising edge:
  - Accepted when the slot is RESERVED and commit_addr == slot*SLOT_STRIDE: slot becomes VALID, stores commit_m/commit_n, stamp = seq, seq++.
  - Otherwise commit_error pulse and no state change.
  - A commit landing during SCAN takes effect from the next cycle; slots already scanned keep their sampled values.
- alloc_cancel: RESERVED to FREE in one cycle. It does not abort a scan in progress; a slot that then wins is re-reserved.
- clear_all: same effect as reset on slot table and seq. FSM returns to IDLE; pending alloc_valid is suppressed.
- Simultaneity: clear_all > alloc_cancel > commit > DECIDE reservation on the same slot in the same cycle.
- query_*: registered on every clk from query_slot; query_valid=1 only for VALID slots. Fields are zero for FREE slots and hold stored values otherwise.
- valid_count: registered population count, updated the cycle after any status change.

Test Plan:
- Reset, alloc 3x4, hold req → alloc_valid at cycle 18 with slot 0, addr 0. No second grant while req held; commit (0,3,4,0) → query slot 0 gives valid=1, m=3, n=4; valid_count=1.
- limit=2; alloc+commit 2x2 three times → slots 0,1 then third grant slot 0 (oldest 2x2, evicted); valid_count 2 after commit.
- Fill 16 slots with distinct sizes, limit=1, request new 5x5 → slot 0 granted (oldest overall).
- 16 slots RESERVED, new alloc → alloc_error pulse, no grant; alloc_cancel → next alloc grants slot 0.
- alloc_m=0 or 17 → alloc_error after 1 cycle; commit to FREE slot 5 or wrong addr → commit_error, valid_count unchanged.
- Assert rst_n low at SCAN cycle 8 → all outputs 0; release, alloc 1x1 → slot 0 at cycle 18.

Source files
------------

// File: rtl/matrix_slot_manager_if.sv
// Alloc/commit/query bus between matrix producers/consumers and the slot manager.
interface matrix_slot_manager_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic                  alloc_req;
  logic [4:0]            alloc_m;
  logic [4:0]            alloc_n;
  logic                  alloc_valid;
  logic [3:0]            alloc_slot;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  alloc_error;

  logic                  commit_req;
  logic [3:0]            commit_slot;
  logic [4:0]            commit_m;
  logic [4:0]            commit_n;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic                  commit_error;

  logic [3:0]            query_slot;
  logic                  query_valid;
  logic [4:0]            query_m;
  logic [4:0]            query_n;
  logic [ADDR_WIDTH-1:0] query_addr;

  modport master (
    output alloc_req, alloc_m, alloc_n,
    output commit_req, commit_slot, commit_m, commit_n, commit_addr,
    output query_slot,
    input  alloc_valid, alloc_slot, alloc_addr, alloc_error,
    input  commit_error, query_valid, query_m, query_n, query_addr
  );

  modport slave (
    input  alloc_req, alloc_m, alloc_n,
    input  commit_req, commit_slot, commit_m, commit_n, commit_addr,
    input  query_slot,
    output alloc_valid, alloc_slot, alloc_addr, alloc_error,
    output commit_error, query_valid, query_m, query_n, query_addr
  );
endinterface

// File: rtl/matrix_slot_manager.sv
// Slot bookkeeper for 16 matrix regions: sequential 16-cycle scan allocator with
// same-size eviction, edge-triggered commit, and a registered lookup port.
module matrix_slot_manager #(
  parameter int ADDR_WIDTH  = 12,
  parameter int SLOT_STRIDE = 256,
  parameter int NUM_SLOTS   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] config_matrices_per_size_i,
  input  logic       alloc_cancel_i,
  input  logic       clear_all_i,
  output logic [4:0] valid_count_o,
  matrix_slot_manager_if.slave bus
);

  typedef enum logic [1:0] {S_FREE, S_RES, S_VALID} slot_st_e;
  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, GRANT, WAIT_DROP} fsm_e;

  function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [3:0] s);
    return ADDR_WIDTH'(32'(s) * SLOT_STRIDE);
  endfunction

  slot_st_e              st_q    [NUM_SLOTS];
  logic [4:0]            m_q     [NUM_SLOTS];
  logic [4:0]            n_q     [NUM_SLOTS];
  logic [7:0]            stamp_q [NUM_SLOTS];
  logic [7:0]            seq_q;

  fsm_e                  state_q;
  logic [3:0]            scan_idx_q;
  logic [4:0]            lat_m_q, lat_n_q;
  logic                  free_found_q, same_found_q, old_found_q;
  logic [3:0]            free_slot_q, same_slot_q, old_slot_q;
  logic [4:0]            same_cnt_q;
  logic                  alloc_valid_q, alloc_error_q;
  logic [3:0]            alloc_slot_q;
  logic [ADDR_WIDTH-1:0] alloc_addr_q;

  logic                  commit_req_q, commit_error_q;
  logic                  query_valid_q;
  logic [4:0]            query_m_q, query_n_q;
  logic [ADDR_WIDTH-1:0] query_addr_q;
  logic [4:0]            valid_count_q;

  // Scan-cycle view of the slot under inspection and the age comparisons.
  slot_st_e   cur_st;
  logic       cur_same;
  logic [7:0] cur_age, same_best_age, old_best_age;
  logic [7:0] limit;
  logic       dec_ok;
  logic [3:0] dec_slot;
  logic       reserve_en;
  logic       bad_dims;
  logic       cm_rise, cm_ok, cm_accept;
  logic [4:0] pop;

  always_comb begin
    cur_st        = st_q[scan_idx_q];
    cur_same      = (m_q[scan_idx_q] == lat_m_q) && (n_q[scan_idx_q] == lat_n_q);
    cur_age       = seq_q - stamp_q[scan_idx_q];
    same_best_age = seq_q - stamp_q[same_slot_q];
    old_best_age  = seq_q - stamp_q[old_slot_q];
    limit         = (config_matrices_per_size_i == 8'd0) ? 8'd1 : config_matrices_per_size_i;
    bad_dims      = (bus.alloc_m == 5'd0) || (bus.alloc_m > 5'd16) ||
                    (bus.alloc_n == 5'd0) || (bus.alloc_n > 5'd16);

    dec_ok   = 1'b0;
    dec_slot = 4'd0;
    if ({3'b000, same_cnt_q} >= limit) begin
      dec_ok   = same_found_q;
      dec_slot = same_slot_q;
    end else if (free_found_q) begin
      dec_ok   = 1'b1;
      dec_slot = free_slot_q;
    end else if (old_found_q) begin
      dec_ok   = 1'b1;
      dec_slot = old_slot_q;
    end
    reserve_en = (state_q == DECIDE) && dec_ok && !clear_all_i;

    cm_rise   = bus.commit_req && !commit_req_q;
    cm_ok     = cm_rise && (st_q[bus.commit_slot] == S_RES) &&
                (bus.commit_addr == slot_base(bus.commit_slot));
    cm_accept = cm_ok && !alloc_cancel_i;

    pop = 5'd0;
    for (int i = 0; i < NUM_SLOTS; i++) pop = pop + {4'd0, st_q[i] == S_VALID};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      lat_m_q       <= '0;
      lat_n_q       <= '0;
      free_found_q  <= 1'b0;
      same_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
      free_slot_q   <= '0;
      same_slot_q   <= '0;
      old_slot_q    <= '0;
      same_cnt_q    <= '0;
      alloc_valid_q <= 1'b0;
      alloc_error_q <= 1'b0;
      alloc_slot_q  <= '0;
      alloc_addr_q  <= '0;
    end else begin
      alloc_valid_q <= 1'b0;
      alloc_error_q <= 1'b0;
      if (clear_all_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (bus.alloc_req) begin
            if (bad_dims) begin
              alloc_error_q <= 1'b1;
              state_q       <= WAIT_DROP;
            end else begin
              lat_m_q      <= bus.alloc_m;
              lat_n_q      <= bus.alloc_n;
              scan_idx_q   <= '0;
              free_found_q <= 1'b0;
              same_found_q <= 1'b0;
              old_found_q  <= 1'b0;
              same_cnt_q   <= '0;
              state_q      <= SCAN;
            end
          end
          SCAN: begin
            if (cur_st == S_FREE && !free_found_q) begin
              free_found_q <= 1'b1;
              free_slot_q  <= scan_idx_q;
            end
            if (cur_st != S_FREE && cur_same) same_cnt_q <= same_cnt_q + 5'd1;
            // Strict '>' keeps the lowest index on equal ages.
            if (cur_st == S_VALID) begin
              if (cur_same && (!same_found_q || cur_age > same_best_age)) begin
                same_found_q <= 1'b1;
                same_slot_q  <= scan_idx_q;
              end
              if (!old_found_q || cur_age > old_best_age) begin
                old_found_q <= 1'b1;
                old_slot_q  <= scan_idx_q;
              end
            end
            scan_idx_q <= scan_idx_q + 4'd1;
            if (scan_idx_q == 4'(NUM_SLOTS - 1)) state_q <= DECIDE;
          end
          DECIDE: begin
            if (dec_ok) begin
              alloc_valid_q <= 1'b1;
              alloc_slot_q  <= dec_slot;
              alloc_addr_q  <= slot_base(dec_slot);
              state_q       <= GRANT;
            end else begin
              alloc_error_q <= 1'b1;
              state_q       <= WAIT_DROP;
            end
          end
          GRANT:     state_q <= WAIT_DROP;
          WAIT_DROP: if (!bus.alloc_req) state_q <= IDLE;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  // Later writes win: commit over reservation, cancel over commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]    <= S_FREE;
        m_q[i]     <= '0;
        n_q[i]     <= '0;
        stamp_q[i] <= '0;
      end
      seq_q          <= '0;
      commit_req_q   <= 1'b0;
      commit_error_q <= 1'b0;
    end else begin
      commit_req_q <= bus.commit_req;
      if (clear_all_i) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          st_q[i]    <= S_FREE;
          m_q[i]     <= '0;
          n_q[i]     <= '0;
          stamp_q[i] <= '0;
        end
        seq_q          <= '0;
        commit_error_q <= 1'b0;
      end else begin
        commit_error_q <= cm_rise && !cm_ok;
        if (cm_accept) seq_q <= seq_q + 8'd1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (reserve_en && dec_slot == 4'(i)) begin
            st_q[i] <= S_RES;
            m_q[i]  <= lat_m_q;
            n_q[i]  <= lat_n_q;
          end
          if (cm_accept && bus.commit_slot == 4'(i)) begin
            st_q[i]    <= S_VALID;
            m_q[i]     <= bus.commit_m;
            n_q[i]     <= bus.commit_n;
            stamp_q[i] <= seq_q;
          end
          if (alloc_cancel_i && st_q[i] == S_RES) st_q[i] <= S_FREE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_valid_q <= 1'b0;
      query_m_q     <= '0;
      query_n_q     <= '0;
      query_addr_q  <= '0;
      valid_count_q <= '0;
    end else begin
      query_valid_q <= (st_q[bus.query_slot] == S_VALID);
      query_m_q     <= (st_q[bus.query_slot] == S_FREE) ? 5'd0 : m_q[bus.query_slot];
      query_n_q     <= (st_q[bus.query_slot] == S_FREE) ? 5'd0 : n_q[bus.query_slot];
      query_addr_q  <= (st_q[bus.query_slot] == S_FREE) ? '0 : slot_base(bus.query_slot);
      valid_count_q <= pop;
    end
  end

  assign bus.alloc_valid  = alloc_valid_q;
  assign bus.alloc_slot   = alloc_slot_q;
  assign bus.alloc_addr   = alloc_addr_q;
  assign bus.alloc_error  = alloc_error_q;
  assign bus.commit_error = commit_error_q;
  assign bus.query_valid  = query_valid_q;
  assign bus.query_m      = query_m_q;
  assign bus.query_n      = query_n_q;
  assign bus.query_addr   = query_addr_q;
  assign valid_count_o    = valid_count_q;

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Directed bench for matrix_slot_manager: grant latency, eviction, exhaustion, errors, reset.
module tb_matrix_slot_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg;
  logic       cancel, clear;
  logic [4:0] vcnt;

  matrix_slot_manager_if #(.ADDR_WIDTH(12)) bus ();

  matrix_slot_manager #(.ADDR_WIDTH(12), .SLOT_STRIDE(256), .NUM_SLOTS(16)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .config_matrices_per_size_i (cfg),
    .alloc_cancel_i             (cancel),
    .clear_all_i                (clear),
    .valid_count_o              (vcnt),
    .bus                        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_alloc(input logic [4:0] m, input logic [4:0] n, input bit hold,
                          output logic [3:0] slot, output logic [11:0] addr,
                          output int lat, output bit err);
    bus.alloc_m   = m;
    bus.alloc_n   = n;
    bus.alloc_req = 1'b1;
    lat = 0; err = 1'b0; slot = '0; addr = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      lat++;
      if (bus.alloc_valid) begin
        slot = bus.alloc_slot;
        addr = bus.alloc_addr;
        break;
      end
      if (bus.alloc_error) begin
        err = 1'b1;
        break;
      end
    end
    if (!hold) begin
      bus.alloc_req = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic do_commit(input logic [3:0] s, input logic [4:0] m, input logic [4:0] n,
                           input logic [11:0] a, output bit err);
    bus.commit_slot = s;
    bus.commit_m    = m;
    bus.commit_n    = n;
    bus.commit_addr = a;
    bus.commit_req  = 1'b1;
    @(negedge clk);
    err = bus.commit_error;
    bus.commit_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_query(input logic [3:0] s);
    bus.query_slot = s;
    @(negedge clk);
  endtask

  logic [3:0]  slot;
  logic [11:0] addr;
  int          lat, extra, bad;
  bit          err;

  initial begin
    rst_n = 1'b0; cfg = 8'd4; cancel = 1'b0; clear = 1'b0;
    bus.alloc_req = 1'b0; bus.alloc_m = '0; bus.alloc_n = '0;
    bus.commit_req = 1'b0; bus.commit_slot = '0; bus.commit_m = '0;
    bus.commit_n = '0; bus.commit_addr = '0; bus.query_slot = '0;
    repeat (3) @(negedge clk);
    check("rst_alloc_valid", 32'(bus.alloc_valid), 0);
    check("rst_alloc_error", 32'(bus.alloc_error), 0);
    check("rst_commit_error", 32'(bus.commit_error), 0);
    check("rst_query_valid", 32'(bus.query_valid), 0);
    check("rst_valid_count", 32'(vcnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Held request: single grant at 18 cycles, then commit and look up.
    do_alloc(5'd3, 5'd4, 1'b1, slot, addr, lat, err);
    check("t1_latency", lat, 18);
    check("t1_slot", 32'(slot), 0);
    check("t1_addr", 32'(addr), 0);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.alloc_valid) extra++;
    end
    check("t1_no_second_grant", extra, 0);
    bus.alloc_req = 1'b0;
    repeat (2) @(negedge clk);
    do_commit(4'd0, 5'd3, 5'd4, 12'd0, err);
    check("t1_commit_err", 32'(err), 0);
    do_query(4'd0);
    check("t1_q_valid", 32'(bus.query_valid), 1);
    check("t1_q_m", 32'(bus.query_m), 3);
    check("t1_q_n", 32'(bus.query_n), 4);
    check("t1_q_addr", 32'(bus.query_addr), 0);
    check("t1_vcnt", 32'(vcnt), 1);

    // Limit 2: third 2x2 evicts the oldest 2x2 (slot 0).
    do_clear();
    check("t2_vcnt_clear", 32'(vcnt), 0);
    cfg = 8'd2;
    do_alloc(5'd2, 5'd2, 1'b0, slot, addr, lat, err);
    check("t2_a1_slot", 32'(slot), 0);
    do_commit(slot, 5'd2, 5'd2, addr, err);
    do_alloc(5'd2, 5'd2, 1'b0, slot, addr, lat, err);
    check("t2_a2_slot", 32'(slot), 1);
    check("t2_a2_addr", 32'(addr), 256);
    do_commit(slot, 5'd2, 5'd2, addr, err);
    do_alloc(5'd2, 5'd2, 1'b0, slot, addr, lat, err);
    check("t2_a3_slot", 32'(slot), 0);
    do_commit(slot, 5'd2, 5'd2, addr, err);
    check("t2_a3_commit_err", 32'(err), 0);
    check("t2_vcnt", 32'(vcnt), 2);
    do_query(4'd1);
    check("t2_q1_valid", 32'(bus.query_valid), 1);

    // Full table of distinct sizes, limit 1: new size evicts oldest overall.
    do_clear();
    cfg = 8'd1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_alloc(5'(i + 1), 5'd2, 1'b0, slot, addr, lat, err);
      if (slot != 4'(i) || addr != 12'(i * 256) || err) bad++;
      do_commit(slot, 5'(i + 1), 5'd2, addr, err);
      if (err) bad++;
    end
    check("t3_fill_errors", bad, 0);
    check("t3_vcnt", 32'(vcnt), 16);
    do_alloc(5'd5, 5'd5, 1'b0, slot, addr, lat, err);
    check("t3_evict_slot", 32'(slot), 0);
    check("t3_evict_err", 32'(err), 0);

    // All RESERVED: refusal, then cancel frees everything.
    do_clear();
    cfg = 8'd16;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_alloc(5'd1, 5'd1, 1'b0, slot, addr, lat, err);
      if (slot != 4'(i) || err) bad++;
    end
    check("t4_fill_errors", bad, 0);
    do_alloc(5'd1, 5'd1, 1'b0, slot, addr, lat, err);
    check("t4_same_limit_err", 32'(err), 1);
    check("t4_same_limit_lat", lat, 18);
    do_alloc(5'd7, 5'd7, 1'b0, slot, addr, lat, err);
    check("t4_full_err", 32'(err), 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    @(negedge clk);
    do_alloc(5'd7, 5'd7, 1'b0, slot, addr, lat, err);
    check("t4_after_cancel_err", 32'(err), 0);
    check("t4_after_cancel_slot", 32'(slot), 0);

    // Bad dimensions and bad commits.
    do_alloc(5'd0, 5'd3, 1'b0, slot, addr, lat, err);
    check("t5_m0_err", 32'(err), 1);
    check("t5_m0_lat", lat, 1);
    do_alloc(5'd3, 5'd17, 1'b0, slot, addr, lat, err);
    check("t5_n17_err", 32'(err), 1);
    check("t5_n17_lat", lat, 1);
    do_commit(4'd5, 5'd2, 5'd2, 12'd1280, err);
    check("t5_free_commit_err", 32'(err), 1);
    do_commit(4'd0, 5'd7, 5'd7, 12'd256, err);
    check("t5_addr_commit_err", 32'(err), 1);
    check("t5_vcnt_unchanged", 32'(vcnt), 0);
    do_query(4'd5);
    check("t5_q5_valid", 32'(bus.query_valid), 0);
    check("t5_q5_m", 32'(bus.query_m), 0);
    do_commit(4'd0, 5'd7, 5'd7, 12'd0, err);
    check("t5_good_commit_err", 32'(err), 0);
    check("t5_vcnt", 32'(vcnt), 1);

    // Reset in the middle of a scan.
    bus.query_slot = 4'd0;
    bus.alloc_m = 5'd1; bus.alloc_n = 5'd1; bus.alloc_req = 1'b1;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    bus.alloc_req = 1'b0;
    @(negedge clk);
    check("t6_rst_alloc_valid", 32'(bus.alloc_valid), 0);
    check("t6_rst_alloc_slot", 32'(bus.alloc_slot), 0);
    check("t6_rst_query_valid", 32'(bus.query_valid), 0);
    check("t6_rst_vcnt", 32'(vcnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_alloc(5'd1, 5'd1, 1'b0, slot, addr, lat, err);
    check("t6_latency", lat, 18);
    check("t6_slot", 32'(slot), 0);
    check("t6_err", 32'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
